// File: rtl/riscv_instr_tcm.sv
// Instruction TCM: fetch port plus host/DMA load port, zero scrub after reset, fixed read latency.
// Define INSTR_TCM_PARITY_EN to store per-byte even parity (36-bit words) and flag mismatches as errors.
//
// state | meaning
// ------+---------------------------------------------------------
// INIT  | writing zero to word[scrub_cnt]; no grants, requests ignored
// RUN   | serving fetch/load, one array access per cycle
module riscv_instr_tcm #(
   parameter int ADDR_W     = 12,
   parameter int READ_LAT   = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        ld_req_i,
   input  logic        ld_we_i,
   input  logic [31:0] ld_addr_i,
   input  logic [3:0]  ld_be_i,
   input  logic [31:0] ld_wdata_i,
   output logic        ld_gnt_o,
   output logic        ld_rvalid_o,
   output logic [31:0] ld_rdata_o,
   output logic        ld_err_o,
   output logic        init_done_o
);

   localparam int DEPTH = 2**ADDR_W;
`ifdef INSTR_TCM_PARITY_EN
   localparam int MEM_W = 36;
`else
   localparam int MEM_W = 32;
`endif
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W:0] SCRUB_LAST  = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [SW-1:0]   STARVE_LOAD = SW'(STARVE_MAX);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   scrub_cnt;
   logic [SW-1:0]     starve_left;
   logic [MEM_W-1:0]  mem [DEPTH];

   logic              ld_win;
   logic [31:0]       acc_addr;
   logic [ADDR_W-1:0] acc_idx;
   logic              acc_oor, acc_we, acc_rd;
   logic              unused_addr_lsb;

   logic [MEM_W-1:0]  rd_raw;
   logic              fv1, lv1, oor1, we1;
   logic [31:0]       resp_data;
   logic              resp_err;
   logic [31:0]       i_data_q, l_data_q;
   logic              i_err_q, l_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_INIT;
         scrub_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) scrub_cnt <= scrub_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt   = state;
      ld_win      = 1'b0;
      instr_gnt_o = 1'b0;
      ld_gnt_o    = 1'b0;
      case (state)
         ST_INIT: if (scrub_cnt == SCRUB_LAST) state_nxt = ST_RUN;
         ST_RUN: begin
            ld_win      = ld_req_i && (!instr_req_i || (starve_left == '0));
            ld_gnt_o    = ld_win;
            instr_gnt_o = instr_req_i && !ld_win;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   assign init_done_o = (state == ST_RUN);

   // Down-counter of denied load cycles left before the load port is forced through.
   always_ff @(posedge clk) begin
      if (rst || !ld_req_i || ld_gnt_o) starve_left <= STARVE_LOAD;
      else if (starve_left != '0)       starve_left <= starve_left - 1'b1;
   end

   assign acc_addr        = ld_gnt_o ? ld_addr_i : instr_addr_i;
   assign acc_idx         = acc_addr[ADDR_W+1:2];
   assign acc_oor         = |acc_addr[31:ADDR_W+2];
   assign acc_we          = ld_gnt_o && ld_we_i;
   assign acc_rd          = (instr_gnt_o || ld_gnt_o) && !acc_we && !acc_oor;
   assign unused_addr_lsb = ^acc_addr[1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_INIT) begin
            mem[scrub_cnt[ADDR_W-1:0]] <= '0;
         end else if (acc_we && !acc_oor) begin
            for (int b = 0; b < 4; b++) begin
               if (ld_be_i[b]) begin
                  mem[acc_idx][8*b +: 8] <= ld_wdata_i[8*b +: 8];
`ifdef INSTR_TCM_PARITY_EN
                  mem[acc_idx][32+b] <= ^ld_wdata_i[8*b +: 8];
`endif
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc_rd) rd_raw <= mem[acc_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fv1  <= 1'b0;
         lv1  <= 1'b0;
         oor1 <= 1'b0;
         we1  <= 1'b0;
      end else begin
         fv1  <= instr_gnt_o;
         lv1  <= ld_gnt_o;
         oor1 <= acc_oor;
         we1  <= acc_we;
      end
   end

   // Writes and out-of-range accesses answer with zero data; raw bits are returned even on a parity error.
   always_comb begin
      resp_data = rd_raw[31:0];
      resp_err  = 1'b0;
`ifdef INSTR_TCM_PARITY_EN
      for (int b = 0; b < 4; b++) begin
         if ((^rd_raw[8*b +: 8]) != rd_raw[32+b]) resp_err = 1'b1;
      end
`endif
      if (oor1 || we1) begin
         resp_data = '0;
         resp_err  = oor1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_data_q <= '0;
         i_err_q  <= 1'b0;
         l_data_q <= '0;
         l_err_q  <= 1'b0;
      end else begin
         if (fv1) begin
            i_data_q <= resp_data;
            i_err_q  <= resp_err;
         end
         if (lv1) begin
            l_data_q <= resp_data;
            l_err_q  <= resp_err;
         end
      end
   end

   generate
      if (READ_LAT == 2) begin : g_lat2
         logic i_rv_q, l_rv_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               i_rv_q <= 1'b0;
               l_rv_q <= 1'b0;
            end else begin
               i_rv_q <= fv1;
               l_rv_q <= lv1;
            end
         end
         assign instr_rvalid_o = i_rv_q;
         assign instr_rdata_o  = i_data_q;
         assign instr_err_o    = i_err_q;
         assign ld_rvalid_o    = l_rv_q;
         assign ld_rdata_o     = l_data_q;
         assign ld_err_o       = l_err_q;
      end else begin : g_lat1
         assign instr_rvalid_o = fv1;
         assign instr_rdata_o  = fv1 ? resp_data : i_data_q;
         assign instr_err_o    = fv1 ? resp_err  : i_err_q;
         assign ld_rvalid_o    = lv1;
         assign ld_rdata_o     = lv1 ? resp_data : l_data_q;
         assign ld_err_o       = lv1 ? resp_err  : l_err_q;
      end
   endgenerate

endmodule

// File: tb/tb_riscv_instr_tcm.sv
// Bench for riscv_instr_tcm: READ_LAT=1 and READ_LAT=2 instances on shared stimulus,
// with a reference memory model feeding per-port response scoreboards.
module tb_riscv_instr_tcm;

   localparam int AW    = 4;
   localparam int DEPTH = 2**AW;
   localparam int SMAX  = 4;
   localparam int SBD   = 32;
`ifdef INSTR_TCM_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      logic [31:0] due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        ld_req, ld_we;
   logic [31:0] ld_addr, ld_wdata;
   logic [3:0]  ld_be;

   logic        i_gnt [2];
   logic        i_rv  [2];
   logic [31:0] i_rd  [2];
   logic        i_err [2];
   logic        l_gnt [2];
   logic        l_rv  [2];
   logic [31:0] l_rd  [2];
   logic        l_err [2];
   logic        done  [2];

   logic [31:0] mdl  [DEPTH];
   logic        pbad [DEPTH];
   exp_t        sb   [4][SBD];
   int          wp   [4];
   int          rp   [4];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   riscv_instr_tcm #(.ADDR_W(AW), .READ_LAT(1), .STARVE_MAX(SMAX)) dut0 (
      .clk(clk), .rst(rst),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(i_gnt[0]),
      .instr_rvalid_o(i_rv[0]), .instr_rdata_o(i_rd[0]), .instr_err_o(i_err[0]),
      .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_be_i(ld_be),
      .ld_wdata_i(ld_wdata), .ld_gnt_o(l_gnt[0]), .ld_rvalid_o(l_rv[0]),
      .ld_rdata_o(l_rd[0]), .ld_err_o(l_err[0]), .init_done_o(done[0]));

   riscv_instr_tcm #(.ADDR_W(AW), .READ_LAT(2), .STARVE_MAX(SMAX)) dut1 (
      .clk(clk), .rst(rst),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(i_gnt[1]),
      .instr_rvalid_o(i_rv[1]), .instr_rdata_o(i_rd[1]), .instr_err_o(i_err[1]),
      .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_be_i(ld_be),
      .ld_wdata_i(ld_wdata), .ld_gnt_o(l_gnt[1]), .ld_rvalid_o(l_rv[1]),
      .ld_rdata_o(l_rd[1]), .ld_err_o(l_err[1]), .init_done_o(done[1]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic is_oor(input logic [31:0] a);
      return |a[31:AW+2];
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      return is_oor(a) ? 32'h0 : mdl[a[AW+1:2]];
   endfunction

   function automatic logic exp_perr(input logic [31:0] a);
      return !is_oor(a) && PAR && pbad[a[AW+1:2]];
   endfunction

   task automatic push(input int ch, input logic [31:0] d, input logic e, input int due);
      sb[ch][wp[ch] % SBD] = '{data: d, err: e, due: due};
      wp[ch]++;
   endtask

   task automatic got_resp(input int ch, input logic rv, input logic [31:0] rd, input logic er);
      exp_t e;
      if (rv) begin
         if (rp[ch] == wp[ch]) begin
            chk($sformatf("unexpected_rvalid_ch%0d", ch), {31'b0, rv}, 32'h0);
         end else begin
            e = sb[ch][rp[ch] % SBD];
            rp[ch]++;
            chk($sformatf("rdata_ch%0d", ch), rd, e.data);
            chk($sformatf("err_ch%0d", ch), {31'b0, er}, {31'b0, e.err});
            chk($sformatf("latency_ch%0d", ch), cyc, e.due);
         end
      end
   endtask

   // Scoreboard: compare responses first, then record this cycle's grants, then commit writes.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         got_resp(2*d,   i_rv[d], i_rd[d], i_err[d]);
         got_resp(2*d+1, l_rv[d], l_rd[d], l_err[d]);
      end
      for (int d = 0; d < 2; d++) begin
         if (i_gnt[d])
            push(2*d, exp_rd(instr_addr), is_oor(instr_addr) | exp_perr(instr_addr), cyc + d + 1);
         if (l_gnt[d])
            push(2*d+1, ld_we ? 32'h0 : exp_rd(ld_addr),
                 is_oor(ld_addr) | (!ld_we & exp_perr(ld_addr)), cyc + d + 1);
      end
      if (l_gnt[0] && ld_we && !is_oor(ld_addr)) begin
         for (int b = 0; b < 4; b++)
            if (ld_be[b]) mdl[ld_addr[AW+1:2]][8*b +: 8] = ld_wdata[8*b +: 8];
         if (ld_be[0]) pbad[ld_addr[AW+1:2]] = 1'b0;
      end
      if (rst)
         for (int c = 0; c < 4; c++) rp[c] = wp[c];
   end

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) begin
         mdl[i]  = 32'h0;
         pbad[i] = 1'b0;
      end
   endtask

   task automatic fetch(input logic [31:0] a);
      logic g;
      g = 1'b0;
      instr_req = 1'b1;
      instr_addr = a;
      for (int k = 0; k < 20 && !g; k++) begin
         @(negedge clk);
         g = i_gnt[0];
      end
      chk("fetch_gnt", {31'b0, g}, 32'h1);
      @(posedge clk); #1;
      instr_req = 1'b0;
   endtask

   task automatic ld(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      logic g;
      g = 1'b0;
      ld_req = 1'b1;
      ld_we = we;
      ld_addr = a;
      ld_be = be;
      ld_wdata = wd;
      for (int k = 0; k < 20 && !g; k++) begin
         @(negedge clk);
         g = l_gnt[0];
      end
      chk("ld_gnt", {31'b0, g}, 32'h1);
      @(posedge clk); #1;
      ld_req = 1'b0;
   endtask

   // Called just after rst is released: INIT must last exactly DEPTH cycles with no grants.
   task automatic scrub_wait();
      logic early;
      early = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         early = early | i_gnt[0] | i_gnt[1] | l_gnt[0] | l_gnt[1] | done[0] | done[1];
      end
      chk("init_early", {31'b0, early}, 32'h0);
      @(posedge clk); #1;
      chk("init_done0", {31'b0, done[0]}, 32'h1);
      chk("init_done1", {31'b0, done[1]}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int c = 0; c < 4; c++) begin
         wp[c] = 0;
         rp[c] = 0;
      end
      clear_model();
      rst = 1'b1;
      instr_req = 1'b0; instr_addr = 32'h0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = 32'h0; ld_be = 4'h0; ld_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_i_gnt", {31'b0, i_gnt[d]}, 32'h0);
         chk("rst_i_rv",  {31'b0, i_rv[d]},  32'h0);
         chk("rst_i_rd",  i_rd[d],           32'h0);
         chk("rst_i_err", {31'b0, i_err[d]}, 32'h0);
         chk("rst_l_gnt", {31'b0, l_gnt[d]}, 32'h0);
         chk("rst_l_rv",  {31'b0, l_rv[d]},  32'h0);
         chk("rst_l_rd",  l_rd[d],           32'h0);
         chk("rst_l_err", {31'b0, l_err[d]}, 32'h0);
         chk("rst_done",  {31'b0, done[d]},  32'h0);
      end

      // Fetch held through INIT; granted only once RUN is reached
      instr_req = 1'b1;
      instr_addr = 32'h0000_003C;
      rst = 1'b0;
      scrub_wait();
      chk("first_gnt", {31'b0, i_gnt[0]}, 32'h1);
      @(posedge clk); #1;
      instr_req = 1'b0;

      ld(1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF);
      ld(1'b1, 32'h10, 4'b0001, 32'h0000_00A5);
      fetch(32'h12);
      ld(1'b0, 32'h10, 4'b0000, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) chk("rdata_hold", i_rd[d], 32'hDEAD_BEA5);

      // Read granted right after a write to the same word
      ld(1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D);
      fetch(32'h20);
      ld(1'b1, 32'h14, 4'b0110, 32'h1234_5678);

      // Back-to-back fetch grants
      instr_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         instr_addr = 32'h10 + 32'(4*k);
         @(posedge clk); #1;
      end
      instr_req = 1'b0;

      // Starvation: fetch 4 cycles, load on the 5th, then fetch again
      instr_req = 1'b1; instr_addr = 32'h10;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h24;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("starve_f%0d", k), {31'b0, i_gnt[d]}, (k == 4) ? 32'h0 : 32'h1);
            chk($sformatf("starve_l%0d", k), {31'b0, l_gnt[d]}, (k == 4) ? 32'h1 : 32'h0);
         end
         @(posedge clk); #1;
      end
      instr_req = 1'b0; ld_req = 1'b0;

      // Out-of-range accesses
      ld(1'b1, 32'h0, 4'b1111, 32'h1122_3344);
      fetch(32'h0000_4000);
      ld(1'b1, 32'h0000_4000, 4'b1111, 32'hFFFF_FFFF);
      fetch(32'h0);
      ld(1'b0, 32'h0000_0040, 4'b0000, 32'h0);

      // Corrupt one stored bit of word 5
      repeat (3) @(posedge clk);
      #1;
      dut0.mem[5][3] = ~dut0.mem[5][3];
      dut1.mem[5][3] = ~dut1.mem[5][3];
      mdl[5][3] = ~mdl[5][3];
      pbad[5] = 1'b1;
      fetch(32'h14);
      ld(1'b0, 32'h14, 4'b0000, 32'h0);

      repeat (4) @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) chk($sformatf("drain_ch%0d", c), wp[c] - rp[c], 32'h0);

      // Reset in the cycle after a fetch grant
      instr_req = 1'b1; instr_addr = 32'h10;
      @(negedge clk);
      chk("rst_fetch_gnt", {31'b0, i_gnt[0]}, 32'h1);
      @(posedge clk); #1;
      instr_req = 1'b0;
      rst = 1'b1;
      clear_model();
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) chk("rst_done_drop", {31'b0, done[d]}, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      scrub_wait();
      fetch(32'h10);
      fetch(32'h0);

      repeat (4) @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) chk($sformatf("final_drain_ch%0d", c), wp[c] - rp[c], 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/riscv_instr_tcm.md
# riscv_instr_tcm

Single-port instruction tightly-coupled memory that responds to the core's instruction-fetch request/grant/rvalid interface, plus a secondary load port used by the host/DMA to preload programs. Sits between the IF-stage prefetch buffer and the on-chip instruction SRAM. After reset it scrubs the whole array to zero before granting anything. It then serves fetch and load accesses with a fixed read latency.

## Interface
- ADDR_W, 12: word-address width; array depth DEPTH = 2**ADDR_W words of 32 bits.
- READ_LAT, 1: grant-to-rvalid latency in cycles; legal values 1 or 2 (2 adds an output register).
- STARVE_MAX, 4: consecutive denied load-port cycles after which the load port wins arbitration.
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- instr_req_i  input  1  fetch request.
- instr_addr_i  input  32  fetch byte address; bits [1:0] ignored.
- instr_gnt_o  output  1  fetch grant; combinational from request and state.
- instr_rvalid_o  output  1  fetch read data valid.
- instr_rdata_o  output  32  fetch read data.
- instr_err_o  output  1  fetch error; qualified by instr_rvalid_o.
- ld_req_i  input  1  load-port request.
- ld_we_i  input  1  1 = write, 0 = read.
- ld_addr_i  input  32  load-port byte address; bits [1:0] ignored.
- ld_be_i  input  4  write byte enables.
- ld_wdata_i  input  32  write data.
- ld_gnt_o  output  1  load-port grant.
- ld_rvalid_o  output  1  load response valid; also pulses for writes.
- ld_rdata_o  output  32  load read data; 0 for writes.
- ld_err_o  output  1  load error; qualified by ld_rvalid_o.
- init_done_o  output  1  scrub finished; TCM accepting requests.

## Operation
- FSM states: INIT and RUN.
  - Reset sets state INIT and scrub counter 0.
  - INIT writes zero (with valid parity if enabled) to word[counter], one word per cycle.
  - Counter width is ADDR_W+1. After word DEPTH-1 is written, the next state is RUN.
  - In INIT, both grants are 0 and all requests are ignored.
- Address decode: word index = addr[ADDR_W+1:2].
  - An access is out-of-range if addr[31:ADDR_W+2] != 0. It is granted normally but does not touch the array.
  - Its response returns rdata 0 and err 1. An out-of-range write is dropped.
- Arbitration in RUN (one array access per cycle):
  - Fetch has priority.
  - starve_cnt increments each cycle ld_req_i=1 and ld_gnt_o=0. It clears on a load grant or when ld_req_i=0.
  - When starve_cnt == STARVE_MAX and both ports request, load wins and fetch is denied that cycle.
  - With a single requester, that requester is always granted.
- Writes honor ld_be_i per byte.
- Responses are in order per port. There is no backpressure: the requester must accept an rvalid when it occurs.
- A read granted in the cycle after a write to the same word returns the new data.
- Errors:
  - instr_err_o and ld_err_o are set for out-of-range accesses.
  - With the parity feature, they are also set for parity mismatch.

## Timing
- Reset values: instr_gnt_o 0, instr_rvalid_o 0, instr_rdata_o 0, instr_err_o 0; ld_gnt_o 0, ld_rvalid_o 0, ld_rdata_o 0, ld_err_o 0; init_done_o 0.
- Scrub timing: the first scrub write is in the first cycle with rst low. init_done_o rises exactly DEPTH cycles later and stays 1 until the next reset.
- Grant G in cycle N gives rvalid in cycle N+READ_LAT. Back-to-back grants give back-to-back rvalids.
- The rvalid pulse is 1 cycle. rdata and err are held until the next rvalid on that port.
- rst asserted mid-operation:
  - All in-flight responses are discarded; no rvalid appears after reset.
  - The scrub restarts at word 0 and array contents are lost.
- Request deasserted after grant: the response is still delivered.

## Configuration
- INSTR_TCM_PARITY_EN:
  - Defined: the array is 36 bits wide, with even parity per byte computed on write and scrub.
  - A byte-enabled write recomputes parity only for enabled bytes.
  - A read with any parity mismatch sets err; rdata still returns the raw 32 bits.
- Undefined: the array is 32 bits wide and err reflects only out-of-range.

## Test plan
- Scrub: ADDR_W=4 → release rst; init_done_o rises after exactly 16 cycles. Request during INIT is not granted. A fetch of 0x0000_003C then returns 0x0000_0000 with err 0.
- Load then fetch: write 0xDEAD_BEEF at 0x10 with be=4'b1111, then write 0xA5 with be=4'b0001. Fetch 0x12 → rdata 0xDEAD_BEA5, rvalid at N+READ_LAT for READ_LAT=1 and for READ_LAT=2.
- Starvation: instr_req_i and ld_req_i held at 1 with STARVE_MAX=4 → fetch is granted 4 cycles, load is granted on the 5th, then fetch resumes.
- Out-of-range: ADDR_W=12, fetch 0x0000_4000 → granted, rvalid with rdata 0 and instr_err_o 1. A load write to 0x0000_4000 leaves word 0 unchanged.
- Reset mid-flight: assert rst in the cycle after a fetch grant → no instr_rvalid_o, init_done_o drops to 0, and the scrub restarts.
- Parity (INSTR_TCM_PARITY_EN): force a bit flip in stored word 5, fetch 0x14 → instr_err_o 1. The same test without the macro gives instr_err_o 0.
